ram_arbiter: RTL

// Round-robin arbiter sharing one port of the single-port synchronous ram among NUM_REQ requesters.

---
 rtl/ram_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing one single-port ram among NUM_REQ requesters
module ram_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_BITS = 8,
    parameter int WORD_BITS = 8
) (
    input  logic                                in_clk,
    input  logic                                in_rst,
    input  logic [NUM_REQ-1:0]                  in_req,
    input  logic [NUM_REQ-1:0]                  in_we,
    input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]   in_addr,
    input  logic [NUM_REQ-1:0][WORD_BITS-1:0]   in_data,
    output logic [NUM_REQ-1:0]                  out_ack,
    output logic [WORD_BITS-1:0]                out_data,
    output logic [NUM_REQ-1:0]                  out_grant,
    output logic                                out_busy,
    output logic                                out_ram_read_ena,
    output logic                                out_ram_write_ena,
    output logic [ADDR_BITS-1:0]                out_ram_addr,
    output logic [WORD_BITS-1:0]                out_ram_data,
    input  logic [WORD_BITS-1:0]                in_ram_data
);

    localparam int IDX_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RESPOND = 2'd2,
        S_ACK     = 2'd3
    } state_t;

    state_t                 state_q;
    logic [IDX_BITS-1:0]    rr_ptr_q;
    logic [IDX_BITS-1:0]    grant_idx_q;
    logic                   we_q;
    logic [NUM_REQ-1:0]     grant_q;
    logic [NUM_REQ-1:0]     ack_q;
    logic                   busy_q;
    logic                   ram_read_ena_q;
    logic                   ram_write_ena_q;
    logic [ADDR_BITS-1:0]   ram_addr_q;
    logic [WORD_BITS-1:0]   ram_data_q;
    logic [WORD_BITS-1:0]   data_q;

    logic                   found_d;
    logic [IDX_BITS-1:0]    win_idx_d;
    logic [IDX_BITS:0]      cand_d;
    logic [NUM_REQ-1:0]     win_onehot_d;
    logic [IDX_BITS-1:0]    next_ptr_d;

    // Round-robin search: first active request at or above the pointer, wrapping at NUM_REQ.
    always_comb begin
        found_d   = 1'b0;
        win_idx_d = '0;
        cand_d    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_d = {1'b0, rr_ptr_q} + (IDX_BITS+1)'(k);
            if (cand_d >= (IDX_BITS+1)'(NUM_REQ)) begin
                cand_d = cand_d - (IDX_BITS+1)'(NUM_REQ);
            end
            if (!found_d && in_req[cand_d[IDX_BITS-1:0]]) begin
                found_d   = 1'b1;
                win_idx_d = cand_d[IDX_BITS-1:0];
            end
        end
    end

    // One-hot form of the winner and the pointer value that follows the current owner.
    always_comb begin
        win_onehot_d = NUM_REQ'(1) << win_idx_d;
        if (grant_idx_q == IDX_BITS'(NUM_REQ - 1)) begin
            next_ptr_d = '0;
        end else begin
            next_ptr_d = grant_idx_q + 1'b1;
        end
    end

    // Transaction sequencer; every output is a register so the ram sees glitch-free controls.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q         <= S_IDLE;
            rr_ptr_q        <= '0;
            grant_idx_q     <= '0;
            we_q            <= 1'b0;
            grant_q         <= '0;
            ack_q           <= '0;
            busy_q          <= 1'b0;
            ram_read_ena_q  <= 1'b0;
            ram_write_ena_q <= 1'b0;
            ram_addr_q      <= '0;
            ram_data_q      <= '0;
            data_q          <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        state_q         <= S_ACCESS;
                        grant_idx_q     <= win_idx_d;
                        grant_q         <= win_onehot_d;
                        busy_q          <= 1'b1;
                        we_q            <= in_we[win_idx_d];
                        ram_write_ena_q <= in_we[win_idx_d];
                        ram_read_ena_q  <= ~in_we[win_idx_d];
                        ram_addr_q      <= in_addr[win_idx_d];
                        ram_data_q      <= in_we[win_idx_d] ? in_data[win_idx_d] : '0;
                    end
                end
                S_ACCESS: begin
                    // The ram has sampled the access on this edge; release its port.
                    state_q         <= S_RESPOND;
                    ram_read_ena_q  <= 1'b0;
                    ram_write_ena_q <= 1'b0;
                    ram_addr_q      <= '0;
                    ram_data_q      <= '0;
                end
                S_RESPOND: begin
                    // Ram output register now holds the read word.
                    state_q <= S_ACK;
                    data_q  <= we_q ? '0 : in_ram_data;
                    ack_q   <= grant_q;
                end
                S_ACK: begin
                    state_q  <= S_IDLE;
                    ack_q    <= '0;
                    grant_q  <= '0;
                    busy_q   <= 1'b0;
                    rr_ptr_q <= next_ptr_d;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_ack           = ack_q;
    assign out_data          = data_q;
    assign out_grant         = grant_q;
    assign out_busy          = busy_q;
    assign out_ram_read_ena  = ram_read_ena_q;
    assign out_ram_write_ena = ram_write_ena_q;
    assign out_ram_addr      = ram_addr_q;
    assign out_ram_data      = ram_data_q;

endmodule
